// File: rtl/ram_rd_stream_pkg.sv
// Shared types and sizing helpers for the RAM read streamer.
// Latency: none (declarations only).
// Backpressure: n/a.
package ram_rd_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Smallest output FIFO that still sustains one word per cycle: the
  // reads in flight in the RAM plus one word being popped and one landing.
  function automatic int min_out_depth(input int ram_latency);
    return ram_latency + 2;
  endfunction

endpackage

// File: rtl/ram_rd_stream_if.sv
// Command, RAM read port and output stream of the RAM read streamer.
// Latency: none (wires only).
// Backpressure: out_rdy from the consumer, cmd_rdy towards the requester.
interface ram_rd_stream_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 9,
  parameter int LEN_W = 16
);
  logic             cmd_vld;
  logic             cmd_rdy;
  logic [AW-1:0]    cmd_add;
  logic [LEN_W-1:0] cmd_len;
  logic             ram_rd_en;
  logic [AW-1:0]    ram_rd_add;
  logic [WIDTH-1:0] ram_rd_data;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;

  // The streamer itself.
  modport master (
    input  cmd_vld, cmd_add, cmd_len, ram_rd_data, out_rdy,
    output cmd_rdy, ram_rd_en, ram_rd_add, out_vld, out_data, out_last, busy
  );

  // The surrounding requester, RAM and consumer.
  modport slave (
    output cmd_vld, cmd_add, cmd_len, ram_rd_data, out_rdy,
    input  cmd_rdy, ram_rd_en, ram_rd_add, out_vld, out_data, out_last, busy
  );
endinterface

// File: rtl/ram_rd_stream_fifo.sv
// Small synchronous FIFO holding captured RAM words plus their last flag.
// Latency: write visible at the head one cycle later; head is read combinationally.
// Backpressure: writes when full and reads when empty are ignored; the caller keeps credit.
module ram_rd_stream_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          a_rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          wr_ok, rd_ok;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;

  // Storage needs no reset: entries are only observed behind a non-zero count.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (rd_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/ram_rd_stream.sv
// Burst reader: walks a 1R1W RAM from a start address and streams the words out with a last flag.
// Latency: first read 1 cycle after command accept, first out_vld RAM_LATENCY+2 cycles after accept.
// Backpressure: credit counter stalls reads so out_rdy low never drops RAM data.
module ram_rd_stream
  import ram_rd_stream_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 512,
  parameter int RAM_LATENCY = 1,
  parameter int LEN_W       = 16,
  parameter int OUT_DEPTH   = min_out_depth(RAM_LATENCY)
) (
  input logic             clk,
  input logic             a_rst_n,
  ram_rd_stream_if.master bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CRW = $clog2(OUT_DEPTH + 1);
  localparam logic [AW-1:0]  ADD_MAX    = AW'(DEPTH - 1);
  localparam logic [CRW-1:0] CREDIT_MAX = CRW'(OUT_DEPTH);

  state_e                 state_q, state_d;
  logic [AW-1:0]          add_cnt_q, add_cnt_d;
  logic [LEN_W-1:0]       rem_q, rem_d;
  logic [CRW-1:0]         credit_q, credit_d;
  logic [RAM_LATENCY-1:0] pipe_vld_q, pipe_last_q;
  logic                   cmd_rdy, busy, issue, accept, last_issue, pop;
  logic                   fifo_full, fifo_empty, out_vld, out_last;
  logic [WIDTH:0]         fifo_rd_data;
  logic [WIDTH-1:0]       out_data;
  logic [CRW-1:0]         unused_fifo_count;

  // State register.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: accept -> RUN, final read issued -> DRAIN, final word popped -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_issue) state_d = DRAIN;
      DRAIN:   if (pop && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State decode: handshake, busy, and read issue gated by credit (full is a backstop).
  always_comb begin
    cmd_rdy = 1'b0;
    busy    = 1'b1;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_rdy = 1'b1;
        busy    = 1'b0;
      end
      RUN:     issue = (credit_q != '0) && !fifo_full;
      default: ;
    endcase
  end

  assign accept     = cmd_rdy & bus.cmd_vld;
  assign last_issue = issue && (rem_q == '0);

  // Address/remaining counters load on accept and step once per issued read.
  always_comb begin
    add_cnt_d = add_cnt_q;
    rem_d     = rem_q;
    if (accept) begin
      add_cnt_d = bus.cmd_add;
      rem_d     = bus.cmd_len;
    end else if (issue) begin
      add_cnt_d = (add_cnt_q == ADD_MAX) ? '0 : add_cnt_q + 1'b1;
      rem_d     = rem_q - 1'b1;
    end
  end

  // Credit counts free FIFO slots not already claimed by reads in flight.
  always_comb begin
    credit_d = credit_q;
    case ({issue, pop})
      2'b10:   credit_d = credit_q - 1'b1;
      2'b01:   credit_d = credit_q + 1'b1;
      default: ;
    endcase
  end

  // Counter registers.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      add_cnt_q <= '0;
      rem_q     <= '0;
      credit_q  <= CREDIT_MAX;
    end else begin
      add_cnt_q <= add_cnt_d;
      rem_q     <= rem_d;
      credit_q  <= credit_d;
    end
  end

  // In-flight pipe mirrors the RAM latency; clearing it drops responses on reset.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
    end else begin
      pipe_vld_q[0]  <= issue;
      pipe_last_q[0] <= last_issue;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
      end
    end
  end

  ram_rd_stream_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (OUT_DEPTH),
    .CW    (CRW)
  ) u_fifo (
    .clk     (clk),
    .a_rst_n (a_rst_n),
    .wr_en   (pipe_vld_q[RAM_LATENCY-1]),
    .wr_data ({pipe_last_q[RAM_LATENCY-1], bus.ram_rd_data}),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (unused_fifo_count)
  );

  // Head of the FIFO is the stream; forced to zero while empty so reset shows clean outputs.
  assign out_vld  = !fifo_empty;
  assign pop      = out_vld & bus.out_rdy;
  assign out_data = out_vld ? fifo_rd_data[WIDTH-1:0] : '0;
  assign out_last = out_vld & fifo_rd_data[WIDTH];

  assign bus.cmd_rdy    = cmd_rdy;
  assign bus.busy       = busy;
  assign bus.ram_rd_en  = issue;
  assign bus.ram_rd_add = add_cnt_q;
  assign bus.out_vld    = out_vld;
  assign bus.out_data   = out_data;
  assign bus.out_last   = out_last;
endmodule

// File: tb/tb_ram_rd_stream.sv
// Directed plus randomized bench for ram_rd_stream against a word-list reference model.
// Latency: checks exact issue/output cycles on unthrottled bursts.
// Backpressure: holds and randomizes out_rdy, checking order, stability and outstanding reads.
module tb_ram_rd_stream;
  localparam int WIDTH = 12;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int LAT   = 3;
  localparam int OUT_D = 5;
  localparam int LEN_W = 16;

  logic clk;
  logic a_rst_n = 1'b1;
  int   cyc = 0;
  int   passed = 0, total = 0, fails = 0;

  ram_rd_stream_if #(.WIDTH(WIDTH), .AW(AW), .LEN_W(LEN_W)) bus ();

  ram_rd_stream #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .RAM_LATENCY(LAT), .LEN_W(LEN_W), .OUT_DEPTH(OUT_D)
  ) dut (
    .clk     (clk),
    .a_rst_n (a_rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle number, advanced on every active edge.
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: word i holds 0x100+i, returned LAT cycles after the address is presented.
  logic [WIDTH-1:0] ram_pipe [LAT];
  always @(posedge clk) begin
    ram_pipe[0] <= 12'h100 + 12'(bus.ram_rd_add);
    for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign bus.ram_rd_data = ram_pipe[LAT-1];

  // Observation logs, filled on the inactive edge.
  logic [31:0] rd_cyc[$], rd_add[$], pop_cyc[$], pop_dat[$], pop_last[$];
  int   vld_cnt = 0, outst = 0, max_outst = 0, stab_err = 0, nxt_outst;
  logic hold_prev = 1'b0, prev_last;
  logic [WIDTH-1:0] prev_dat;
  logic pop_w;
  assign pop_w     = bus.out_vld & bus.out_rdy;
  assign nxt_outst = outst + int'(bus.ram_rd_en) - int'(pop_w);

  // Record reads, pops, reads not yet consumed, and any head change while stalled.
  always @(negedge clk) begin
    if (!a_rst_n) begin
      outst     <= 0;
      hold_prev <= 1'b0;
    end else begin
      if (bus.ram_rd_en) begin
        rd_cyc.push_back(32'(cyc));
        rd_add.push_back(32'(bus.ram_rd_add));
      end
      if (bus.out_vld) vld_cnt <= vld_cnt + 1;
      if (pop_w) begin
        pop_cyc.push_back(32'(cyc));
        pop_dat.push_back(32'(bus.out_data));
        pop_last.push_back(32'(bus.out_last));
      end
      outst <= nxt_outst;
      if (nxt_outst > max_outst) max_outst <= nxt_outst;
      if (hold_prev && (!bus.out_vld || bus.out_data !== prev_dat || bus.out_last !== prev_last))
        stab_err <= stab_err + 1;
      hold_prev <= bus.out_vld && !bus.out_rdy;
      prev_dat  <= bus.out_data;
      prev_last <= bus.out_last;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd_rdy"},    32'(bus.cmd_rdy), 1);
    chk({tag, "_ram_rd_en"},  32'(bus.ram_rd_en), 0);
    chk({tag, "_ram_rd_add"}, 32'(bus.ram_rd_add), 0);
    chk({tag, "_out_vld"},    32'(bus.out_vld), 0);
    chk({tag, "_out_last"},   32'(bus.out_last), 0);
    chk({tag, "_out_data"},   32'(bus.out_data), 0);
    chk({tag, "_busy"},       32'(bus.busy), 0);
  endtask

  // Called just after an active edge; returns the cycle in which the command was accepted.
  task automatic send_cmd(input int add, input int len, output int t);
    int n = 0;
    while (!bus.cmd_rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    bus.cmd_vld = 1'b1;
    bus.cmd_add = AW'(add);
    bus.cmd_len = LEN_W'(len);
    t = cyc;
    @(posedge clk); #1;
    bus.cmd_vld = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd_rdy, output int ret);
    ret = -1;
    for (int i = 0; i < 400 && ret < 0; i++) begin
      if (rnd_rdy) bus.out_rdy = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (bus.cmd_rdy) ret = cyc;
    end
    bus.out_rdy = 1'b1;
  endtask

  // Reference: word k of a burst reads address (add+k) mod DEPTH; only the final word is last.
  task automatic compare_burst(input string tag, input int add, input int len, input int t,
                               input bit timing, input int rb, input int pb);
    int ea;
    logic [31:0] o;
    chk({tag, "_nrd"},  32'(rd_add.size() - rb), 32'(len + 1));
    chk({tag, "_npop"}, 32'(pop_dat.size() - pb), 32'(len + 1));
    for (int k = 0; k <= len; k++) begin
      ea = (add + k) % DEPTH;
      o = (rb + k < rd_add.size()) ? rd_add[rb+k] : 'x;
      chk($sformatf("%s_rdadd%0d", tag, k), o, 32'(ea));
      o = (pb + k < pop_dat.size()) ? pop_dat[pb+k] : 'x;
      chk($sformatf("%s_data%0d", tag, k), o, 32'(256 + ea));
      o = (pb + k < pop_last.size()) ? pop_last[pb+k] : 'x;
      chk($sformatf("%s_last%0d", tag, k), o, 32'(k == len));
      if (timing) begin
        o = (rb + k < rd_cyc.size()) ? rd_cyc[rb+k] : 'x;
        chk($sformatf("%s_rdcyc%0d", tag, k), o, 32'(t + 1 + k));
        o = (pb + k < pop_cyc.size()) ? pop_cyc[pb+k] : 'x;
        chk($sformatf("%s_popcyc%0d", tag, k), o, 32'(t + LAT + 2 + k));
      end
    end
  endtask

  task automatic run_burst(input string tag, input int add, input int len,
                           input bit timing, input bit rnd_rdy);
    int rb, pb, t, ret;
    rb = rd_add.size();
    pb = pop_dat.size();
    send_cmd(add, len, t);
    wait_idle(rnd_rdy, ret);
    chk({tag, "_done"}, 32'(ret >= 0), 1);
    if (timing) chk({tag, "_idle_cyc"}, 32'(ret), 32'(t + LAT + len + 3));
    compare_burst(tag, add, len, t, timing, rb, pb);
  endtask

  // Directed sequence followed by randomized bursts.
  initial begin
    int t, rb, pb, ret, v0;
    bus.cmd_vld = 1'b0;
    bus.cmd_add = '0;
    bus.cmd_len = '0;
    bus.out_rdy = 1'b1;
    #2 a_rst_n = 1'b0;
    #1 check_reset("rst");
    repeat (3) @(posedge clk);
    #1 a_rst_n = 1'b1;
    @(posedge clk); #1;

    run_burst("basic", 2, 3, 1'b1, 1'b0);
    run_burst("wrap", 14, 3, 1'b1, 1'b0);

    // Consumer stalled: only OUT_D reads may be issued, then everything drains in order.
    rb = rd_add.size();
    pb = pop_dat.size();
    bus.out_rdy = 1'b0;
    send_cmd(0, 9, t);
    while (cyc < t + 20) begin
      @(posedge clk); #1;
    end
    chk("bp_reads_stalled", 32'(rd_add.size() - rb), OUT_D);
    chk("bp_no_pop", 32'(pop_dat.size() - pb), 0);
    chk("bp_rd_en_low", 32'(bus.ram_rd_en), 0);
    chk("bp_vld_held", 32'(bus.out_vld), 1);
    bus.out_rdy = 1'b1;
    wait_idle(1'b0, ret);
    chk("bp_done", 32'(ret >= 0), 1);
    compare_burst("bp", 0, 9, t, 1'b0, rb, pb);

    run_burst("single", 7, 0, 1'b1, 1'b0);

    // Reset in the middle of a burst: outputs clear at once and nothing emerges afterwards.
    send_cmd(0, 7, t);
    while (cyc < t + 3) begin
      @(posedge clk); #1;
    end
    a_rst_n = 1'b0;
    #1 check_reset("mid_rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_rst_n = 1'b1;
    rb = rd_add.size();
    v0 = vld_cnt;
    repeat (12) begin
      @(posedge clk); #1;
    end
    chk("mid_rst_no_vld", 32'(vld_cnt - v0), 0);
    chk("mid_rst_no_rd", 32'(rd_add.size() - rb), 0);
    chk("mid_rst_idle", 32'(bus.cmd_rdy), 1);
    run_burst("post_rst", 3, 5, 1'b1, 1'b0);

    // Random consumer readiness over random bursts.
    for (int r = 0; r < 3; r++)
      run_burst($sformatf("rnd%0d", r), int'($urandom_range(0, DEPTH - 1)),
                (r == 0) ? 15 : int'($urandom_range(0, 20)), 1'b0, 1'b1);

    chk("max_outstanding", 32'(max_outst), OUT_D);
    chk("stable_while_stalled", 32'(stab_err), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", passed, total);
    $fatal(1, "watchdog expired");
  end
endmodule
